hamming_serial_encoder: RTL and testbench
=========================================

HAMMING_SERIAL_ENCODER -- requirements
Module: hamming_serial_encoder

Interface
REQ-001 Parameter IDLE_GAP, default 0: idle cycles inserted after each frame before the next frame may be accepted.
REQ-002 Parameter MSB_FIRST, default 0: 0 sends codeword bit 0 first; 1 sends the highest bit first.
REQ-003 Port clk, input, 1: the single clock; all logic is rising-edge clocked.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port data_in, input, 4: nibble to encode, as {d4,d3,d2,d1}.
REQ-006 Port in_valid, input, 1: data_in is valid.
REQ-007 Port in_ready, output, 1: the block accepts data this cycle.
REQ-008 Port enable, input, 1: shift enable; low stalls serialization.
REQ-009 Port serial_out, output, 1: current code bit.
REQ-010 Port serial_valid, output, 1: serial_out carries a valid bit this cycle.
REQ-011 Port frame_start, output, 1: one-cycle pulse coincident with the first valid bit.
REQ-012 Port frame_done, output, 1: one-cycle pulse coincident with the last valid bit.

Function
REQ-013 Parity bits: p1=d1^d2^d4, p2=d1^d3^d4, p4=d2^d3^d4.
REQ-014 Codeword bits [6:0] = {d4,d3,d2,p4,d1,p2,p1}; bit i is Hamming position i+1.
REQ-015 Handshake: a transfer occurs when in_valid && in_ready; data_in is captured into a shift register in that cycle.
REQ-016 FSM states:
- IDLE -> SHIFT on transfer.
- SHIFT -> GAP after the last bit when IDLE_GAP>0.
- SHIFT -> IDLE after the last bit when IDLE_GAP=0 and no new transfer.
- GAP -> IDLE after IDLE_GAP cycles.
REQ-017 in_ready is high in IDLE, and also in SHIFT on the last-bit cycle with enable=1 when IDLE_GAP=0; frames then run back-to-back with no dead cycle.
REQ-018 Latency: transfer in cycle N puts the first bit on serial_out with serial_valid=1 in cycle N+1.
REQ-019 The frame occupies FRAME_W consecutive enabled cycles.
REQ-020 A 3-bit bit counter counts 0..FRAME_W-1, then wraps to 0 on frame end or on a back-to-back reload.
REQ-021 While enable=0 in SHIFT:
- serial_valid=0, frame_start=0, frame_done=0.
- Counter and shift register hold.
- The bit resumes unchanged when enable returns to 1.
REQ-022 enable is ignored in IDLE and GAP; the GAP counter always advances.
REQ-023 in_valid with in_ready=0 is not captured; data_in changes outside a transfer do not affect a frame in flight.
REQ-024 Outside SHIFT: serial_out=0, serial_valid=0.

Reset
REQ-025 On reset=1 at a clock edge:
- state=IDLE; counters and shift register cleared.
- serial_out=0, serial_valid=0, frame_start=0, frame_done=0, in_ready=1 in the following cycle.
REQ-026 Reset mid-frame aborts the frame immediately; no partial bits follow and no frame_done is emitted.

Configuration
REQ-027 Macro HAMMING_TX_SECDED_EN defined:
- FRAME_W=8.
- An overall parity bit p0 = XOR of codeword[6:0] is sent as the final bit for MSB_FIRST=0, or the first bit for MSB_FIRST=1.
REQ-028 Macro HAMMING_TX_SECDED_EN undefined: FRAME_W=7 and p0 logic is absent.

Structure
REQ-029 Shared package hamming_pkg holds DATA_W=4, CODE_W=7, the state enum typedef, and the codeword bit-position constants.
REQ-030 A combinational sub-module hamming_encoder (4-bit data in, 7-bit codeword out) is instantiated once; FSM and serializer live in the top.

Verification
REQ-031 Cases, all with MSB_FIRST=0 and IDLE_GAP=0 unless stated:
- Nibble 4'b1011, enable=1: bits 1,0,1,0,1,0,1 (codeword 7'h55) in cycles N+1..N+7; frame_start at N+1, frame_done at N+7. With SECDED: 8th bit = 0.
- Nibble 4'b0001: codeword 7'h07, bits 1,1,1,0,0,0,0. With SECDED: p0=1.
- Back-to-back 4'h0 then 4'hF with in_valid held: 14 contiguous valid cycles; second frame = 1111111.
- enable dropped for 3 cycles after bit 2 of 4'b1011: serial_valid low 3 cycles, then bits 3..6 as expected.
- reset asserted at bit 4: serial_valid=0 next cycle, no frame_done, in_ready=1; the next transfer starts a fresh frame.
- IDLE_GAP=2: in_ready low for 2 cycles after frame_done, then high.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) serial transmitter.
// Configuration macro: HAMMING_TX_SECDED_EN. When defined, an overall parity
// bit p0 extends each frame to 8 bits (SECDED). When undefined, frames are 7 bits.
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CODE_W = 7;

`ifdef HAMMING_TX_SECDED_EN
    localparam int FRAME_W = 8;
`else
    localparam int FRAME_W = 7;
`endif

    // Bit counter width: enough for 0..7, which covers both frame sizes.
    localparam int CNT_W = 3;

    // Codeword bit positions. Bit i holds Hamming position i+1.
    localparam int POS_P1 = 0;
    localparam int POS_P2 = 1;
    localparam int POS_D1 = 2;
    localparam int POS_P4 = 3;
    localparam int POS_D2 = 4;
    localparam int POS_D3 = 5;
    localparam int POS_D4 = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage : hamming_pkg

// File: rtl/hamming_encoder.sv
// Combinational Hamming(7,4) encoder: nibble {d4,d3,d2,d1} to 7-bit codeword.
module hamming_encoder
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [CODE_W-1:0] code_o
);

    logic d1, d2, d3, d4;

    assign {d4, d3, d2, d1} = data_i;

    // Place data and parity bits at their Hamming positions.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        code_o         = '0;
        code_o[POS_P1] = d1 ^ d2 ^ d4;
        code_o[POS_P2] = d1 ^ d3 ^ d4;
        code_o[POS_D1] = d1;
        code_o[POS_P4] = d2 ^ d3 ^ d4;
        code_o[POS_D2] = d2;
        code_o[POS_D3] = d3;
        code_o[POS_D4] = d4;
    end

endmodule : hamming_encoder

// File: rtl/hamming_serial_encoder.sv
// Hamming(7,4) serial transmitter: accepts a nibble on a valid/ready handshake,
// encodes it and shifts the frame out one bit per enabled cycle.
// Configuration macro: HAMMING_TX_SECDED_EN appends overall parity p0 as frame
// bit 7 (sent last for LSB-first, first for MSB-first).
module hamming_serial_encoder
    import hamming_pkg::*;
#(
    parameter int IDLE_GAP  = 0,
    parameter bit MSB_FIRST = 1'b0
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              enable,
    output logic              serial_out,
    output logic              serial_valid,
    output logic              frame_start,
    output logic              frame_done
);

    // Gap counter runs 0..IDLE_GAP-1; keep at least one bit when unused.
    localparam int                GAP_W    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_W - 1);

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [CODE_W-1:0]  code;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] shifted;
    logic               in_shift;
    logic               step;
    logic               last_bit;
    logic               transfer;
    logic               cur_bit;

    hamming_encoder u_encoder (
        .data_i (data_in),
        .code_o (code)
    );

`ifdef HAMMING_TX_SECDED_EN
    // Overall parity over the seven code bits rides on top as frame bit 7.
    assign frame = {^code, code};
`else
    assign frame = code;
`endif

    assign in_shift = (state_q == ST_SHIFT);
    assign step     = in_shift && enable;
    assign last_bit = (bit_cnt_q == LAST_BIT);
    assign cur_bit  = MSB_FIRST ? shift_q[FRAME_W-1] : shift_q[0];
    assign shifted  = MSB_FIRST ? {shift_q[FRAME_W-2:0], 1'b0}
                                : {1'b0, shift_q[FRAME_W-1:1]};

    // Back-to-back reload is only offered when no idle gap is required.
    assign in_ready = (state_q == ST_IDLE) || ((IDLE_GAP == 0) && step && last_bit);
    assign transfer = in_valid && in_ready;

    // A stalled cycle presents no valid bit; the held bit reappears on resume.
    assign serial_valid = step;
    assign serial_out   = in_shift && cur_bit;
    assign frame_start  = step && (bit_cnt_q == '0);
    assign frame_done   = step && last_bit;

    // Next-state logic for the FSM, shift register and counters.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    state_d   = ST_SHIFT;
                    shift_d   = frame;
                    bit_cnt_d = '0;
                end
            end

            ST_SHIFT: begin
                if (enable) begin
                    shift_d = shifted;
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        if (transfer) begin
                            shift_d = frame;
                        end else if (IDLE_GAP > 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

endmodule : hamming_serial_encoder

// File: tb/tb_hamming_serial_encoder.sv
// Scoreboard bench for hamming_serial_encoder: stimulus pushes expected bits,
// a monitor pops and compares whenever serial_valid is high.
`timescale 1ns/1ps
module tb_hamming_serial_encoder;

`ifdef HAMMING_TX_SECDED_EN
    localparam int               FW    = 8;
    localparam logic [FW-1:0]    EXP_B = 8'h55;  // 1011 -> 7'h55, p0=0
    localparam logic [FW-1:0]    EXP_1 = 8'h87;  // 0001 -> 7'h07, p0=1
    localparam logic [FW-1:0]    EXP_0 = 8'h00;  // 0000 -> 7'h00, p0=0
    localparam logic [FW-1:0]    EXP_F = 8'hFF;  // 1111 -> 7'h7F, p0=1
`else
    localparam int               FW    = 7;
    localparam logic [FW-1:0]    EXP_B = 7'h55;
    localparam logic [FW-1:0]    EXP_1 = 7'h07;
    localparam logic [FW-1:0]    EXP_0 = 7'h00;
    localparam logic [FW-1:0]    EXP_F = 7'h7F;
`endif

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   run_len  = 0;
    int   last_run = 0;
    bit   mon_en   = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] data_in;
    logic       in_valid, in_ready, enable;
    logic       serial_out, serial_valid, frame_start, frame_done;

    logic [3:0] g_data_in;
    logic       g_in_valid, g_in_ready, g_enable;
    logic       g_serial_out, g_serial_valid, g_frame_start, g_frame_done;

    always #5 clk = ~clk;

    hamming_serial_encoder #(.IDLE_GAP(0), .MSB_FIRST(1'b0)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .enable       (enable),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .frame_done   (frame_done)
    );

    hamming_serial_encoder #(.IDLE_GAP(2), .MSB_FIRST(1'b0)) u_gap (
        .clk          (clk),
        .reset        (reset),
        .data_in      (g_data_in),
        .in_valid     (g_in_valid),
        .in_ready     (g_in_ready),
        .enable       (g_enable),
        .serial_out   (g_serial_out),
        .serial_valid (g_serial_valid),
        .frame_start  (g_frame_start),
        .frame_done   (g_frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offer a nibble until accepted, queueing the first nbits expected bits.
    // Called just after a rising edge; returns just after the transfer edge.
    task automatic transfer(input logic [3:0] d, input logic [FW-1:0] code, input int nbits);
        int   waited;
        exp_t e;
        waited   = 0;
        data_in  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("accept", in_ready, 1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        for (int k = 0; k < nbits; k++) begin
            e.b     = code[k];
            e.first = (k == 0);
            e.last  = (k == FW - 1);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the scoreboard to empty, then realign after an edge.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each valid bit against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (serial_valid === 1'b1) begin
                    run_len++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_bit", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("bit_start_done", {serial_out, frame_start, frame_done}, mon_e);
                    end
                end else begin
                    if (run_len != 0) last_run = run_len;
                    run_len = 0;
                    check("idle_pulses", {serial_valid, frame_start, frame_done}, 0);
                end
            end
        end
    end

    initial begin
        int n;
        reset      = 1'b1;
        data_in    = 4'h0;
        in_valid   = 1'b0;
        enable     = 1'b1;
        g_data_in  = 4'h0;
        g_in_valid = 1'b0;
        g_enable   = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_serial_valid", serial_valid, 0);
        check("rst_serial_out",   serial_out,   0);
        check("rst_pulses",       {frame_start, frame_done}, 0);
        check("rst_in_ready",     in_ready,     1);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Nibble 1011; data_in changes after capture must not disturb the frame.
        transfer(4'b1011, EXP_B, FW);
        in_valid = 1'b0;
        data_in  = 4'h6;
        drain("drain_1011");

        // Nibble 0001.
        transfer(4'b0001, EXP_1, FW);
        in_valid = 1'b0;
        drain("drain_0001");

        // Back-to-back 0 then F with in_valid held: contiguous valid run.
        transfer(4'h0, EXP_0, FW);
        transfer(4'hF, EXP_F, FW);
        in_valid = 1'b0;
        drain("drain_b2b");
        @(negedge clk);
        #1;
        check("b2b_run_len", last_run, 2 * FW);
        @(posedge clk);
        #1;

        // Stall for 3 cycles after bit 2 of 1011.
        transfer(4'b1011, EXP_B, FW);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", serial_valid, 0);
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        drain("drain_stall");

        // Reset while bit 4 is on the line: frame aborted, no frame_done.
        transfer(4'b1011, EXP_B, 5);
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("abort_valid",    serial_valid, 0);
        check("abort_done",     frame_done,   0);
        check("abort_in_ready", in_ready,     1);
        check("abort_queue",    exp_q.size(), 0);
        @(posedge clk);
        #1;
        transfer(4'b0001, EXP_1, FW);
        in_valid = 1'b0;
        drain("drain_after_abort");

        // IDLE_GAP=2 instance: in_ready low for 2 cycles after frame_done.
        g_data_in  = 4'b0001;
        g_in_valid = 1'b1;
        @(negedge clk);
        check("gap_accept", g_in_ready, 1);
        @(posedge clk);
        #1;
        g_in_valid = 1'b0;
        g_data_in  = 4'hA;
        @(negedge clk);
        check("gap_first_bit", {g_serial_valid, g_frame_start, g_serial_out}, 3'b111);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!g_frame_done && n < 20);
        check("gap_frame_done", g_frame_done, 1);
        check("gap_done_cycle", n, FW - 1);
        @(negedge clk);
        check("gap_ready_lo1", g_in_ready, 0);
        @(negedge clk);
        check("gap_ready_lo2", g_in_ready, 0);
        @(negedge clk);
        check("gap_ready_hi",  g_in_ready, 1);

        repeat (3) @(posedge clk);
        check("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hamming_serial_encoder
